// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: walks each instruction through FETCH/DECODE/EXEC/MEM/WB,
// drives datapath selects and strobes, counts retired instructions, and latches traps.
module multicycle_control #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_write,
  output logic             oldpc_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic             alu_src_b,
  output logic [2:0]       imm_sel,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);
  localparam logic TO_EN = (TIMEOUT > 0);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        cause_q, cause_d;
  logic [CNT_W-1:0]  instret_q, instret_d;

  // Immediate format per opcode; 7 means no immediate (R-type or illegal)
  function automatic logic [2:0] imm_for(input logic [6:0] op);
    case (op)
      OP_IMM, OP_LOAD: imm_for = 3'd0;
      OP_STORE:        imm_for = 3'd1;
      OP_BRANCH:       imm_for = 3'd2;
      OP_AUIPC:        imm_for = 3'd3;
      OP_JAL:          imm_for = 3'd4;
      default:         imm_for = 3'd7;
    endcase
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_AUIPC, OP_JAL, OP_BRANCH: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= {WAIT_W{1'b0}};
      cause_q   <= 2'd0;
      instret_q <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = {WAIT_W{1'b0}};
    cause_d     = cause_q;
    instret_d   = instret_q;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_write    = 1'b0;
    oldpc_write = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'd0;
    alu_src_a   = 1'b0;
    alu_src_b   = 1'b0;
    imm_sel     = 3'd7;
    reg_write   = 1'b0;
    wb_sel      = 2'd0;
    trap        = 1'b0;
    trap_cause  = cause_q;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write    = 1'b1;
          oldpc_write = 1'b1;
          pc_write    = 1'b1;
          state_d     = S_DECODE;
        end else if (TO_EN && (wait_q == WAIT_LIMIT)) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        imm_sel = imm_for(opcode);
        if (is_legal(opcode)) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = 2'd1;
        end
      end
      S_EXEC: begin
        imm_sel = imm_for(opcode);
        case (opcode)
          OP_R:   state_d = S_WB;
          OP_IMM: begin
            alu_src_b = 1'b1;
            state_d   = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_b = 1'b1;
            state_d   = S_MEM;
          end
          OP_AUIPC: begin
            alu_src_a = 1'b1;
            alu_src_b = 1'b1;
            state_d   = S_WB;
          end
          OP_JAL: begin
            pc_write = 1'b1;
            pc_src   = 2'd1;
            state_d  = S_WB;
          end
          OP_BRANCH: begin
            pc_write  = branch_taken;
            pc_src    = 2'd1;
            state_d   = S_FETCH;
            instret_d = instret_q + CNT_W'(1);
          end
          // Opcode changed after DECODE: treat as illegal rather than guess
          default: begin
            state_d = S_TRAP;
            cause_d = 2'd1;
          end
        endcase
      end
      S_MEM: begin
        imm_sel  = imm_for(opcode);
        dmem_req = 1'b1;
        dmem_we  = (opcode == OP_STORE);
        if (dmem_ready) begin
          if (opcode == OP_STORE) begin
            state_d   = S_FETCH;
            instret_d = instret_q + CNT_W'(1);
          end else begin
            state_d = S_WB;
          end
        end else if (TO_EN && (wait_q == WAIT_LIMIT)) begin
          state_d = S_TRAP;
          cause_d = 2'd3;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        imm_sel   = imm_for(opcode);
        reg_write = 1'b1;
        if (opcode == OP_LOAD) begin
          wb_sel = 2'd1;
        end else if (opcode == OP_JAL) begin
          wb_sel = 2'd2;
        end else begin
          wb_sel = 2'd0;
        end
        state_d   = S_FETCH;
        instret_d = instret_q + CNT_W'(1);
      end
      S_TRAP: trap = 1'b1;
      default: begin
        trap    = 1'b1;
        state_d = S_TRAP;
      end
    endcase
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench: per-instruction expectations come from a
// cycle-count/pulse-count model of the instruction timing rules.
module tb_multicycle_control;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic clk, reset;
  logic [6:0] opcode;
  logic branch_taken, imem_ready, dmem_ready;
  logic imem_req, dmem_req, dmem_we, ir_write, oldpc_write, pc_write;
  logic [1:0] pc_src;
  logic alu_src_a, alu_src_b;
  logic [2:0] imm_sel;
  logic reg_write;
  logic [1:0] wb_sel;
  logic trap;
  logic [1:0] trap_cause;
  logic [CNT_W-1:0] instret;

  int checks = 0;
  int errors = 0;

  multicycle_control #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_write(ir_write),
    .oldpc_write(oldpc_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_sel(imm_sel),
    .reg_write(reg_write), .wb_sel(wb_sel), .trap(trap),
    .trap_cause(trap_cause), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: instruction-level timing and pulse expectations
  function automatic bit is_mem(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic int exp_cycles(input logic [6:0] op, input int idl, input int ddl);
    if (op == OP_BRANCH) return idl + 3;
    if (op == OP_STORE)  return idl + ddl + 4;
    if (op == OP_LOAD)   return idl + ddl + 5;
    return idl + 4;
  endfunction

  function automatic int exp_imm(input logic [6:0] op);
    case (op)
      OP_IMM, OP_LOAD: return 0;
      OP_STORE:        return 1;
      OP_BRANCH:       return 2;
      OP_AUIPC:        return 3;
      OP_JAL:          return 4;
      default:         return 7;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in its first FETCH cycle, a few ns after a rising edge
  task automatic do_reset();
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic run_instr(input logic [6:0] op, input logic bt, input int idl,
                           input int ddl, input string tag);
    int n, n_imem, n_dmem, n_ir, n_oldpc, n_pcw, n_rw, imm_bad;
    int wb_at_rw, pcsrc_last, a_any, b_any, we_any;
    int e_pcw, e_rw, e_wb, e_a, e_b, e_we, e_dmem;
    logic [CNT_W-1:0] base;
    n = exp_cycles(op, idl, ddl);
    n_imem = 0; n_dmem = 0; n_ir = 0; n_oldpc = 0; n_pcw = 0; n_rw = 0; imm_bad = 0;
    wb_at_rw = -1; pcsrc_last = -1; a_any = 0; b_any = 0; we_any = 0;
    base = instret;
    for (int k = 0; k < n; k++) begin
      opcode = op;
      branch_taken = bt;
      imem_ready = (k == idl);
      dmem_ready = is_mem(op) && (k == idl + 3 + ddl);
      #2;
      if (imem_req) n_imem++;
      if (dmem_req) n_dmem++;
      if (dmem_we) we_any = 1;
      if (ir_write) n_ir++;
      if (oldpc_write) n_oldpc++;
      if (pc_write) begin
        n_pcw++;
        pcsrc_last = int'(pc_src);
      end
      if (reg_write) begin
        n_rw++;
        wb_at_rw = int'(wb_sel);
      end
      if (alu_src_a) a_any = 1;
      if (alu_src_b) b_any = 1;
      if (k > idl && int'(imm_sel) != exp_imm(op)) imm_bad++;
      step();
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    e_pcw  = ((op == OP_JAL) || (op == OP_BRANCH && bt)) ? 2 : 1;
    e_rw   = (op == OP_BRANCH || op == OP_STORE) ? 0 : 1;
    e_wb   = (e_rw == 0) ? -1 : (op == OP_LOAD) ? 1 : (op == OP_JAL) ? 2 : 0;
    e_a    = (op == OP_AUIPC) ? 1 : 0;
    e_b    = (op == OP_IMM || is_mem(op) || op == OP_AUIPC) ? 1 : 0;
    e_we   = (op == OP_STORE) ? 1 : 0;
    e_dmem = is_mem(op) ? ddl + 1 : 0;
    checks++; if (n_imem != idl + 1) begin errors++; $display("FAIL %s imem_req cycles got %0d exp %0d", tag, n_imem, idl + 1); end
    checks++; if (n_dmem != e_dmem) begin errors++; $display("FAIL %s dmem_req cycles got %0d exp %0d", tag, n_dmem, e_dmem); end
    checks++; if (n_ir != 1 || n_oldpc != 1) begin errors++; $display("FAIL %s ir/oldpc pulses got %0d/%0d exp 1/1", tag, n_ir, n_oldpc); end
    checks++; if (n_pcw != e_pcw) begin errors++; $display("FAIL %s pc_write pulses got %0d exp %0d", tag, n_pcw, e_pcw); end
    checks++; if (pcsrc_last != e_pcw - 1) begin errors++; $display("FAIL %s last pc_src got %0d exp %0d", tag, pcsrc_last, e_pcw - 1); end
    checks++; if (n_rw != e_rw) begin errors++; $display("FAIL %s reg_write pulses got %0d exp %0d", tag, n_rw, e_rw); end
    checks++; if (wb_at_rw != e_wb) begin errors++; $display("FAIL %s wb_sel got %0d exp %0d", tag, wb_at_rw, e_wb); end
    checks++; if (a_any != e_a || b_any != e_b) begin errors++; $display("FAIL %s alu_src a/b got %0d/%0d exp %0d/%0d", tag, a_any, b_any, e_a, e_b); end
    checks++; if (we_any != e_we) begin errors++; $display("FAIL %s dmem_we got %0d exp %0d", tag, we_any, e_we); end
    checks++; if (imm_bad != 0) begin errors++; $display("FAIL %s imm_sel wrong in %0d cycles exp %0d", tag, imm_bad, exp_imm(op)); end
    checks++; if (instret - base !== 32'd1) begin errors++; $display("FAIL %s instret delta got %0d exp 1", tag, instret - base); end
    checks++; if (imem_req !== 1'b1 || trap !== 1'b0) begin errors++; $display("FAIL %s back-to-fetch imem_req=%b trap=%b exp 1/0", tag, imem_req, trap); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    opcode = 7'd0; branch_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    repeat (2) step();
    checks++;
    if (imem_req !== 1'b1 || trap !== 1'b0 || trap_cause !== 2'd0 || instret !== 32'd0 ||
        pc_write !== 1'b0 || reg_write !== 1'b0 || dmem_req !== 1'b0 || imm_sel !== 3'd7) begin
      errors++;
      $display("FAIL reset imem_req=%b trap=%b cause=%0d instret=%0d imm=%0d exp 1/0/0/0/7",
               imem_req, trap, trap_cause, instret, imm_sel);
    end
    reset = 1'b0;
    #1;
  endtask

  task automatic test_directed();
    run_instr(OP_IMM,    1'b0, 0, 0, "addi");
    run_instr(OP_LOAD,   1'b0, 0, 3, "lw");
    run_instr(OP_BRANCH, 1'b1, 0, 0, "beq_taken");
    run_instr(OP_BRANCH, 1'b0, 0, 0, "beq_not");
    run_instr(OP_JAL,    1'b0, 0, 0, "jal");
    run_instr(OP_STORE,  1'b0, 0, 2, "sw");
    run_instr(OP_R,      1'b1, 1, 0, "add");
    run_instr(OP_AUIPC,  1'b0, 2, 0, "auipc");
  endtask

  task automatic test_random();
    logic [6:0] ops [7];
    ops = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_AUIPC, OP_JAL, OP_BRANCH};
    for (int i = 0; i < 40; i++) begin
      run_instr(ops[$urandom_range(0, 6)], 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), "random");
    end
  endtask

  task automatic test_illegal();
    logic [CNT_W-1:0] base;
    int bad;
    base = instret;
    opcode = 7'h7F;
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    step();
    checks++;
    if (trap !== 1'b1 || trap_cause !== 2'd1) begin
      errors++; $display("FAIL illegal trap=%b cause=%0d exp 1/1", trap, trap_cause);
    end
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      opcode = 7'($urandom);
      branch_taken = 1'($urandom);
      imem_ready = 1'($urandom);
      dmem_ready = 1'($urandom);
      #2;
      if (trap !== 1'b1 || trap_cause !== 2'd1 || imem_req || dmem_req || ir_write ||
          oldpc_write || pc_write || reg_write) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL trap_hold bad cycles got %0d exp 0", bad); end
    checks++;
    if (instret !== base) begin errors++; $display("FAIL trap_instret got %0d exp %0d", instret, base); end
    checks++;
    if (base == 32'd0) begin errors++; $display("FAIL trap_precond instret got 0 exp nonzero"); end
    do_reset();
    checks++;
    if (instret !== 32'd0 || trap !== 1'b0 || trap_cause !== 2'd0 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL post_reset instret=%0d trap=%b cause=%0d imem_req=%b exp 0/0/0/1",
               instret, trap, trap_cause, imem_req);
    end
  endtask

  task automatic test_timeouts();
    int bad;
    // 16 FETCH cycles without ready: trap on the edge ending the 16th
    opcode = OP_R;
    bad = 0;
    for (int k = 0; k < TIMEOUT + 1; k++) begin
      imem_ready = 1'b0;
      #2;
      if (trap !== 1'b0 || imem_req !== 1'b1) bad++;
      step();
    end
    checks++;
    if (bad != 0 || trap !== 1'b1 || trap_cause !== 2'd2) begin
      errors++; $display("FAIL imem_timeout early=%0d trap=%b cause=%0d exp 0/1/2", bad, trap, trap_cause);
    end
    do_reset();
    // Ready arriving in the 16th cycle wins over the timeout
    run_instr(OP_IMM, 1'b0, TIMEOUT, 0, "imem_late_ready");
    checks++;
    if (trap !== 1'b0) begin errors++; $display("FAIL imem_late_ready trap=%b exp 0", trap); end
    run_instr(OP_LOAD, 1'b0, 0, TIMEOUT, "dmem_late_ready");
    // Load whose data never arrives
    opcode = OP_LOAD;
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    step();
    step();
    bad = 0;
    for (int k = 0; k < TIMEOUT + 1; k++) begin
      #2;
      if (trap !== 1'b0 || dmem_req !== 1'b1) bad++;
      step();
    end
    checks++;
    if (bad != 0 || trap !== 1'b1 || trap_cause !== 2'd3) begin
      errors++; $display("FAIL dmem_timeout early=%0d trap=%b cause=%0d exp 0/1/3", bad, trap, trap_cause);
    end
    do_reset();
  endtask

  task automatic test_reset_in_mem();
    opcode = OP_STORE;
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    step();
    step();
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin
      errors++; $display("FAIL mem_precond dmem_req=%b we=%b exp 1/1", dmem_req, dmem_we);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || imem_req !== 1'b1) begin
      errors++; $display("FAIL reset_in_mem dmem_req=%b we=%b imem_req=%b exp 0/0/1", dmem_req, dmem_we, imem_req);
    end
    reset = 1'b0;
    #1;
    run_instr(OP_IMM, 1'b0, 0, 0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_illegal();
    test_timeouts();
    test_reset_in_mem();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle sequencer for the RV32I core. It steps each instruction through the FETCH, DECODE, EXEC, MEM and WB states. It drives the register-write strobes, the memory request handshakes, the ALU/PC/writeback muxes and the immediate-format select consumed by the immediate generator. It also keeps a retired-instruction counter and raises a sticky trap on an illegal opcode or a memory timeout.

Parameters:
TIMEOUT, 15, cycles a memory request may wait for ready before trapping; 0 disables the timeout.
CNT_W, 32, width of instret counter.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
opcode  input  7  instruction[6:0] from instruction register (valid from DECODE on)
branch_taken  input  1  comparator result for current branch, sampled in EXEC
imem_ready  input  1  instruction memory data valid / accept
dmem_ready  input  1  data memory accept (store) / data valid (load)
imem_req  output  1  instruction fetch request
dmem_req  output  1  data memory request
dmem_we  output  1  1 = store, 0 = load (valid while dmem_req)
ir_write  output  1  load instruction register
oldpc_write  output  1  latch current PC into old_pc
pc_write  output  1  update PC
pc_src  output  2  0 = PC+4, 1 = old_pc+imm (JAL/taken branch)
alu_src_a  output  1  0 = rs1, 1 = old_pc
alu_src_b  output  1  0 = rs2, 1 = imm
imm_sel  output  3  0 = I, 1 = S, 2 = B, 3 = U, 4 = J, 7 = none
reg_write  output  1  register file write strobe
wb_sel  output  2  0 = ALU, 1 = load data, 2 = old_pc+4
trap  output  1  sticky fault flag
trap_cause  output  2  0 = none, 1 = illegal opcode, 2 = imem timeout, 3 = dmem timeout
instret  output  CNT_W  retired instruction count

Behaviour:
- Reset (async, active-high): state = FETCH, wait counter = 0, trap = 0, trap_cause = 0, instret = 0.
- Combinational outputs are decoded from state, opcode and the ready inputs. Every output not named for a state is 0 in that state; imm_sel = 7 where unused.
- Legal opcodes:
  - 0110011 R → imm none
  - 0010011 OP-IMM → I
  - 0000011 LOAD → I
  - 0100011 STORE → S
  - 0010111 AUIPC → U
  - 1101111 JAL → J
  - 1100011 BRANCH → B
- FETCH:
  - imem_req = 1.
  - imem_ready = 1 in the same cycle (zero-wait allowed): ir_write = oldpc_write = pc_write = 1, pc_src = 0, go to DECODE.
  - Otherwise stay in FETCH and increment the wait counter.
- DECODE (1 cycle):
  - Illegal opcode → TRAP, cause 1.
  - Legal opcode → EXEC.
  - imm_sel is driven per the opcode table from DECODE through WB.
- EXEC (1 cycle), by opcode:
  - R: a = 0, b = 0 → WB.
  - OP-IMM: a = 0, b = 1 → WB.
  - LOAD/STORE: a = 0, b = 1 → MEM.
  - AUIPC: a = 1, b = 1 → WB.
  - JAL: pc_write = 1, pc_src = 1 → WB.
  - BRANCH: pc_write = branch_taken, pc_src = 1 → FETCH; the instruction retires.
- MEM:
  - dmem_req = 1, dmem_we = 1 for STORE.
  - On dmem_ready: STORE → FETCH (retires); LOAD → WB.
  - Otherwise stay in MEM and increment the wait counter.
- WB (1 cycle):
  - reg_write = 1.
  - wb_sel: 1 for LOAD, 2 for JAL, 0 otherwise.
  - Go to FETCH; the instruction retires.
- Retirement: instret += 1 on the clock edge leaving a retiring state (BRANCH EXEC, STORE MEM with ready, WB). It wraps modulo 2^CNT_W without saturating.
- Wait counter:
  - Cleared on every state change.
  - With TIMEOUT > 0 and the counter equal to TIMEOUT while ready = 0: go to TRAP, cause 2 (FETCH) or 3 (MEM).
  - Ready arriving in the same cycle the counter reaches TIMEOUT wins: no trap.
- TRAP:
  - Absorbing; only reset exits.
  - trap = 1, trap_cause held, all strobes and reqs 0.
  - instret frozen.
- Reset mid-operation: any request or strobe deasserts immediately, since the state clears asynchronously. A partially completed memory access is abandoned.
- Output hold: no strobe is asserted for more than one cycle per instruction except imem_req and dmem_req, which stay high until ready.

Test Plan:
- ADDI (0x00500093) with imem_ready tied 1 → FETCH, DECODE, EXEC, WB in 4 cycles; imm_sel = 0, alu_src_b = 1, reg_write pulse in WB; instret 0→1.
- LW with dmem_ready delayed 3 cycles → dmem_req high 4 cycles, dmem_we = 0, WB wb_sel = 1, imm_sel = 0; total 8 cycles; instret +1.
- BEQ with branch_taken = 1, then BEQ with branch_taken = 0 → each 3 cycles; pc_write = 1 with pc_src = 1 for the first, pc_write = 0 for the second; no reg_write; instret +2.
- JAL, then SW → JAL: EXEC pc_write = 1, pc_src = 1, then WB reg_write = 1, wb_sel = 2, imm_sel = 4. SW: imm_sel = 1, dmem_we = 1, no reg_write, returns to FETCH on dmem_ready.
- Opcode 0x7F → TRAP after DECODE; trap = 1, trap_cause = 1; stays trapped for 20 cycles under any input until reset; then state is FETCH, instret = 0.
- TIMEOUT = 15 with imem_ready held 0 → trap with trap_cause = 2 at FETCH cycle 16. Repeat with ready raised exactly at cycle 16 → no trap. Assert reset while in MEM → dmem_req drops the same cycle.
